// File: rtl/apu_stereo_pair_fifo.sv
// Stereo pairing stage: joins independent L/R interpolator strobes into
// frames and buffers them in a first-word-fall-through FIFO for the serializer.
module apu_stereo_pair_fifo #(
   parameter int DW       = 24,
   parameter int DEPTH    = 8,
   parameter int SKEW_MAX = 15
) (
   input  logic                       AMCLK_i,
   input  logic                       ARST,
   input  logic [DW-1:0]              APDATA_L_i,
   input  logic                       APDATA_L_VALID_i,
   input  logic [DW-1:0]              APDATA_R_i,
   input  logic                       APDATA_R_VALID_i,
   output logic [DW-1:0]              APDATA_L_o,
   output logic [DW-1:0]              APDATA_R_o,
   output logic                       APDATA_VALID_o,
   input  logic                       APDATA_READY_i,
   output logic [$clog2(DEPTH):0]     FILL_o,
   output logic                       OVERFLOW_o,
   output logic                       SKEW_ERR_o,
   input  logic                       CLR_ERR_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(SKEW_MAX + 1);
   localparam int FW = 2 * DW;

   localparam logic [CW-1:0] SKEW_LIM = CW'(SKEW_MAX);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW:0]   FILL_MAX = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   FILL_ONE = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      WAIT_BOTH,
      HAVE_L,
      HAVE_R
   } pair_state_t;

   pair_state_t   state_q, state_d;
   logic [DW-1:0] hold_q, hold_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_req;
   logic [DW-1:0] push_l, push_r;
   logic          skew_set;

   always_ff @(posedge AMCLK_i or posedge ARST) begin
      if (ARST) begin
         state_q <= WAIT_BOTH;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      push_req = 1'b0;
      push_l   = APDATA_L_i;
      push_r   = APDATA_R_i;
      skew_set = 1'b0;
      unique case (state_q)
         WAIT_BOTH: begin
            if (APDATA_L_VALID_i && APDATA_R_VALID_i) begin
               push_req = 1'b1;
            end else if (APDATA_L_VALID_i) begin
               hold_d  = APDATA_L_i;
               cnt_d   = '0;
               state_d = HAVE_L;
            end else if (APDATA_R_VALID_i) begin
               hold_d  = APDATA_R_i;
               cnt_d   = '0;
               state_d = HAVE_R;
            end
         end
         HAVE_L: begin
            if (APDATA_R_VALID_i) begin
               push_req = 1'b1;
               push_l   = hold_q;
               if (APDATA_L_VALID_i) begin
                  hold_d = APDATA_L_i;
                  cnt_d  = '0;
               end else begin
                  state_d = WAIT_BOTH;
               end
            end else if (APDATA_L_VALID_i) begin
               hold_d   = APDATA_L_i;
               cnt_d    = '0;
               skew_set = 1'b1;
            end else if (cnt_q == SKEW_LIM) begin
               skew_set = 1'b1;
               state_d  = WAIT_BOTH;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HAVE_R: begin
            if (APDATA_L_VALID_i) begin
               push_req = 1'b1;
               push_r   = hold_q;
               if (APDATA_R_VALID_i) begin
                  hold_d = APDATA_R_i;
                  cnt_d  = '0;
               end else begin
                  state_d = WAIT_BOTH;
               end
            end else if (APDATA_R_VALID_i) begin
               hold_d   = APDATA_R_i;
               cnt_d    = '0;
               skew_set = 1'b1;
            end else if (cnt_q == SKEW_LIM) begin
               skew_set = 1'b1;
               state_d  = WAIT_BOTH;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = WAIT_BOTH;
      endcase
   end

   logic [FW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   fill_q;
   logic          full, not_empty, pop, do_push, ovf_set;
   logic [FW-1:0] head;

   assign not_empty = (fill_q != '0);
   assign full      = (fill_q == FILL_MAX);
   assign pop       = not_empty && APDATA_READY_i;
   // A full FIFO still accepts a frame when the head leaves on the same edge
   assign do_push   = push_req && (!full || pop);
   assign ovf_set   = push_req && full && !pop;

   always_ff @(posedge AMCLK_i) begin
      if (do_push) mem[wr_ptr_q] <= {push_l, push_r};
   end

   always_ff @(posedge AMCLK_i or posedge ARST) begin
      if (ARST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (do_push && !pop)      fill_q <= fill_q + FILL_ONE;
         else if (pop && !do_push) fill_q <= fill_q - FILL_ONE;
      end
   end

   always_ff @(posedge AMCLK_i or posedge ARST) begin
      if (ARST) begin
         OVERFLOW_o <= 1'b0;
         SKEW_ERR_o <= 1'b0;
      end else begin
         OVERFLOW_o <= ovf_set  || (OVERFLOW_o && !CLR_ERR_i);
         SKEW_ERR_o <= skew_set || (SKEW_ERR_o && !CLR_ERR_i);
      end
   end

   // Memory is not reset, so data is gated to zero while empty
   assign head           = mem[rd_ptr_q];
   assign APDATA_VALID_o = not_empty;
   assign APDATA_L_o     = not_empty ? head[FW-1:DW] : '0;
   assign APDATA_R_o     = not_empty ? head[DW-1:0] : '0;
   assign FILL_o         = fill_q;

endmodule

// File: tb/tb_apu_stereo_pair_fifo.sv
// Directed bench for apu_stereo_pair_fifo with a frame scoreboard
// checked on every serializer handshake.
module tb_apu_stereo_pair_fifo;

   localparam int DW = 24;
   localparam int DEPTH = 8;
   localparam int SKEW_MAX = 15;

   logic          clk;
   logic          arst;
   logic [DW-1:0] l_i, r_i;
   logic          lv, rv;
   logic [DW-1:0] l_o, r_o;
   logic          valid_o;
   logic          ready;
   logic [3:0]    fill;
   logic          ovf, skew_err;
   logic          clr;

   int checks = 0;
   int errors = 0;
   int nframes = 0;
   int n0;
   logic [47:0] sb [$];
   logic [47:0] exp_f;

   apu_stereo_pair_fifo #(
      .DW(DW), .DEPTH(DEPTH), .SKEW_MAX(SKEW_MAX)
   ) dut (
      .AMCLK_i(clk),
      .ARST(arst),
      .APDATA_L_i(l_i),
      .APDATA_L_VALID_i(lv),
      .APDATA_R_i(r_i),
      .APDATA_R_VALID_i(rv),
      .APDATA_L_o(l_o),
      .APDATA_R_o(r_o),
      .APDATA_VALID_o(valid_o),
      .APDATA_READY_i(ready),
      .FILL_o(fill),
      .OVERFLOW_o(ovf),
      .SKEW_ERR_o(skew_err),
      .CLR_ERR_i(clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] obs,
                      input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic strobe(input logic do_l, input logic [DW-1:0] lval,
                         input logic do_r, input logic [DW-1:0] rval);
      lv  = do_l;
      l_i = lval;
      rv  = do_r;
      r_i = rval;
      tick();
      lv  = 1'b0;
      rv  = 1'b0;
   endtask

   // Handshake monitor: head frame must match the oldest expected frame
   always @(negedge clk) begin
      if (!arst && valid_o && ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_extra observed %h expected none", {l_o, r_o});
         end
         if (sb.size() != 0) begin
            exp_f = sb.pop_front();
            checks++;
            assert ({l_o, r_o} === exp_f) else begin
               errors++;
               $error("FAIL frame observed %h expected %h", {l_o, r_o}, exp_f);
            end
         end
         nframes++;
      end
   end

   initial begin
      arst  = 1'b1;
      l_i   = '0;
      r_i   = '0;
      lv    = 1'b0;
      rv    = 1'b0;
      ready = 1'b0;
      clr   = 1'b0;
      idle(2);
      chk("rst_valid", 48'(valid_o), 48'(0));
      chk("rst_fill", 48'(fill), 48'(0));
      chk("rst_data", {l_o, r_o}, 48'(0));
      chk("rst_flags", 48'({ovf, skew_err}), 48'(0));
      arst = 1'b0;
      idle(1);

      // Simultaneous pair, popped immediately
      ready = 1'b1;
      sb.push_back({24'h123456, 24'hFEDCBA});
      strobe(1'b1, 24'h123456, 1'b1, 24'hFEDCBA);
      chk("t1_valid", 48'(valid_o), 48'(1));
      chk("t1_head", {l_o, r_o}, {24'h123456, 24'hFEDCBA});
      tick();
      chk("t1_valid_after", 48'(valid_o), 48'(0));
      chk("t1_fill", 48'(fill), 48'(0));

      // R arrives five cycles after L
      n0 = nframes;
      sb.push_back({24'h000001, 24'h000002});
      strobe(1'b1, 24'h000001, 1'b0, '0);
      idle(4);
      strobe(1'b0, '0, 1'b1, 24'h000002);
      idle(3);
      chk("t2_frames", 48'(nframes - n0), 48'(1));
      chk("t2_skew", 48'(skew_err), 48'(0));

      // Unpartnered L times out
      n0 = nframes;
      strobe(1'b1, 24'h000033, 1'b0, '0);
      idle(SKEW_MAX + 3);
      chk("t3_timeout_err", 48'(skew_err), 48'(1));
      chk("t3_no_frame", 48'(nframes - n0), 48'(0));
      chk("t3_fill", 48'(fill), 48'(0));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t3_clear", 48'(skew_err), 48'(0));

      // L, L, R: second L pairs
      n0 = nframes;
      sb.push_back({24'h0000A2, 24'h0000B1});
      strobe(1'b1, 24'h0000A1, 1'b0, '0);
      strobe(1'b1, 24'h0000A2, 1'b0, '0);
      chk("t3_replace_err", 48'(skew_err), 48'(1));
      strobe(1'b0, '0, 1'b1, 24'h0000B1);
      idle(3);
      chk("t3_pair_frames", 48'(nframes - n0), 48'(1));
      clr = 1'b1;
      tick();
      clr = 1'b0;

      // Overflow: nine frames into eight slots
      ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         if (i <= DEPTH) sb.push_back({24'(i), 24'(i)});
         strobe(1'b1, 24'(i), 1'b1, 24'(i));
      end
      tick();
      chk("t4_fill", 48'(fill), 48'(8));
      chk("t4_ovf", 48'(ovf), 48'(1));
      chk("t4_head", {l_o, r_o}, {24'd1, 24'd1});
      n0 = nframes;
      ready = 1'b1;
      idle(12);
      chk("t4_drained", 48'(nframes - n0), 48'(8));
      chk("t4_fill_empty", 48'(fill), 48'(0));
      chk("t4_sb_empty", 48'(sb.size()), 48'(0));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t4_ovf_clear", 48'(ovf), 48'(0));

      // Full with simultaneous push and pop
      ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         sb.push_back({24'(12'h100 + i), 24'(12'h300 + i)});
         strobe(1'b1, 24'(12'h100 + i), 1'b1, 24'(12'h300 + i));
      end
      chk("t5_full", 48'(fill), 48'(8));
      ready = 1'b1;
      sb.push_back({24'h000200, 24'h000400});
      strobe(1'b1, 24'h000200, 1'b1, 24'h000400);
      chk("t5_fill_same", 48'(fill), 48'(8));
      chk("t5_no_ovf", 48'(ovf), 48'(0));
      n0 = nframes;
      idle(12);
      chk("t5_drained", 48'(nframes - n0), 48'(8));
      chk("t5_sb_empty", 48'(sb.size()), 48'(0));

      // Reset with buffered frames and a held L
      ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         strobe(1'b1, 24'(12'h500 + i), 1'b1, 24'(12'h600 + i));
      end
      strobe(1'b1, 24'h0000EE, 1'b0, '0);
      chk("t6_fill_pre", 48'(fill), 48'(4));
      #1;
      arst = 1'b1;
      #1;
      chk("t6_rst_valid", 48'(valid_o), 48'(0));
      chk("t6_rst_fill", 48'(fill), 48'(0));
      chk("t6_rst_data", {l_o, r_o}, 48'(0));
      chk("t6_rst_flags", 48'({ovf, skew_err}), 48'(0));
      tick();
      arst = 1'b0;
      sb.delete();
      tick();
      ready = 1'b1;
      n0 = nframes;
      sb.push_back({24'h000066, 24'h000077});
      strobe(1'b0, '0, 1'b1, 24'h000077);
      strobe(1'b1, 24'h000066, 1'b0, '0);
      idle(4);
      chk("t6_frames", 48'(nframes - n0), 48'(1));
      chk("t6_sb_empty", 48'(sb.size()), 48'(0));
      chk("t6_skew", 48'(skew_err), 48'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apu_stereo_pair_fifo.md
Name: apu_stereo_pair_fifo

Overview:
- Sits between the two per-channel FIR interpolators (left/right) and the left-justified serializer in the audio path.
- Pairs the independently-valid 24-bit left and right interpolated samples into stereo frames and buffers them in a small first-word-fall-through FIFO.
- Presents frames to the serializer through a valid/ready handshake.
- Reports channel skew errors and overflow.

Parameters:
- DW, 24, sample width per channel (signed)
- DEPTH, 8, FIFO depth in stereo frames; power of 2, minimum 2
- SKEW_MAX, 15, maximum cycles one channel may wait for its partner

Ports:
- AMCLK_i  in  1  audio master clock; sole clock
- ARST  in  1  reset, asynchronous, active-high
- APDATA_L_i  in  DW  left interpolated sample
- APDATA_L_VALID_i  in  1  left sample strobe (one cycle per sample)
- APDATA_R_i  in  DW  right interpolated sample
- APDATA_R_VALID_i  in  1  right sample strobe
- APDATA_L_o  out  DW  head-of-FIFO left sample
- APDATA_R_o  out  DW  head-of-FIFO right sample
- APDATA_VALID_o  out  1  FIFO not empty
- APDATA_READY_i  in  1  serializer accepts the head frame
- FILL_o  out  log2(DEPTH)+1  current frame count
- OVERFLOW_o  out  1  sticky; a frame was dropped because the FIFO was full
- SKEW_ERR_o  out  1  sticky; a pairing error occurred
- CLR_ERR_i  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All outputs are 0: data, valid, FILL_o, flags.
  - Pairing FSM is in WAIT_BOTH; skew counter is 0; FIFO pointers are 0.
  - Reset mid-operation discards buffered frames and any held half-frame.
- Pairing FSM, three states: WAIT_BOTH, HAVE_L, HAVE_R.
  - WAIT_BOTH, L and R valid in the same cycle: push {L,R}; stay in WAIT_BOTH.
  - WAIT_BOTH, only L valid: latch L; go to HAVE_L; skew counter = 0.
  - WAIT_BOTH, only R valid: latch R; go to HAVE_R; skew counter = 0. Symmetric with the L case.
  - HAVE_L, R valid: push {held L, R}; go to WAIT_BOTH. If L is also valid that cycle, push the pair, latch the new L, and stay in HAVE_L with counter = 0.
  - HAVE_L, L valid without R: replace the held L; set SKEW_ERR_o; counter = 0.
  - HAVE_L, counter reaches SKEW_MAX with no partner: discard the held L; set SKEW_ERR_o; go to WAIT_BOTH.
  - HAVE_R mirrors HAVE_L exactly.
  - The counter increments each cycle in HAVE_L/HAVE_R and saturates at SKEW_MAX.
- FIFO:
  - The push is written on the same edge the pair completes. APDATA_VALID_o rises on the next cycle when the FIFO was empty (1-cycle latency).
  - Outputs are first-word-fall-through: head frame visible while APDATA_VALID_o=1.
  - Pop on the edge where APDATA_VALID_o & APDATA_READY_i.
  - Head data is held stable while valid & !ready.
  - Full, push with no pop: the new frame is dropped; OVERFLOW_o set; FIFO contents unchanged.
  - Full, push and pop in the same cycle: both occur; FILL_o unchanged; no overflow.
  - Empty: APDATA_READY_i is ignored; no underflow, pointers unchanged.
  - Pointers wrap modulo DEPTH. FILL_o is 0..DEPTH and updates one cycle after the push/pop edge, i.e. it is a registered count.
- Flags:
  - Sticky until CLR_ERR_i.
  - If a set event and CLR_ERR_i occur in the same cycle, set wins.
- Arithmetic: no modification of sample values; bit-exact pass-through of both channels.

Test Plan:
- Reset release, then L and R strobes in the same cycle with L=24'h123456, R=24'hFEDCBA, READY=1 -> next cycle VALID=1, L_o=123456, R_o=FEDCBA; popped; VALID=0 the cycle after; FILL_o returns to 0.
- L=24'h000001 strobe, R=24'h000002 strobe 5 cycles later -> exactly one frame {000001,000002}; SKEW_ERR_o stays 0.
- L strobe, no R for SKEW_MAX+1 cycles -> no frame pushed; SKEW_ERR_o=1. CLR_ERR_i pulse -> SKEW_ERR_o=0. Then L,L without R between -> SKEW_ERR_o=1 and the second L is the one that pairs.
- READY=0, push 9 frames with values 1..9 -> FILL_o=8, OVERFLOW_o=1. Then READY=1 -> frames 1..8 pop in order; frame 9 never appears.
- FIFO full, READY=1 and a new pair completing in the same cycle -> FILL_o stays 8; OVERFLOW_o stays 0; the new frame appears after the existing 8.
- ARST asserted mid-stream with 4 frames buffered and HAVE_L pending -> all outputs 0 immediately. After release, the first frame out is the first pair completed post-reset.
